bram_arbiter: RTL

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-master round-robin arbiter onto a single block RAM port with timeout
module bram_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_m0_stb,
  input  logic            i_m0_we,
  input  logic [2:0]      i_m0_sel,
  input  logic [XLEN-1:0] i_m0_addr,
  input  logic [XLEN-1:0] i_m0_data,
  output logic [XLEN-1:0] o_m0_data,
  output logic            o_m0_stall,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  input  logic            i_m1_stb,
  input  logic            i_m1_we,
  input  logic [2:0]      i_m1_sel,
  input  logic [XLEN-1:0] i_m1_addr,
  input  logic [XLEN-1:0] i_m1_data,
  output logic [XLEN-1:0] o_m1_data,
  output logic            o_m1_stall,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  output logic            o_s_stb,
  output logic            o_s_we,
  output logic [2:0]      o_s_sel,
  output logic [XLEN-1:0] o_s_addr,
  output logic [XLEN-1:0] o_s_data,
  input  logic [XLEN-1:0] i_s_data,
  input  logic            i_s_stall,
  input  logic            i_s_ack
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;
  state_t          state_q;
  logic            owner_q, last_q, we_q;
  logic [7:0]      cnt_q;
  logic [2:0]      sel_q;
  logic [XLEN-1:0] addr_q, data_q;
  logic            grant, win, ack, tmo, busy;
  // Grant selection, slave completion and timeout detection; reset masks every handshake
  always_comb begin
    win   = (i_m0_stb && i_m1_stb) ? ~last_q : i_m1_stb;
    grant = !i_reset && state_q == IDLE && (i_m0_stb || i_m1_stb);
    busy  = state_q == ISSUE || state_q == WAIT_ACK;
    ack   = !i_reset && i_s_ack && (state_q == WAIT_ACK || (state_q == ISSUE && !i_s_stall));
    tmo   = !i_reset && busy && !ack && cnt_q == 8'(TIMEOUT - 1);
  end
  assign o_m0_stall = !(grant && !win);
  assign o_m1_stall = !(grant && win);
  assign o_m0_ack   = ack && !owner_q;
  assign o_m1_ack   = ack && owner_q;
  assign o_m0_err   = tmo && !owner_q;
  assign o_m1_err   = tmo && owner_q;
  assign o_m0_data  = i_s_data;
  assign o_m1_data  = i_s_data;
  assign o_s_stb    = !i_reset && state_q == ISSUE;
  assign o_s_we     = we_q;
  assign o_s_sel    = sel_q;
  assign o_s_addr   = addr_q;
  assign o_s_data   = data_q;
  // Arbitration FSM: latch the winner's request, hold it until ack or timeout
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant) begin
          state_q <= ISSUE;
          owner_q <= win;
          last_q  <= win;
          cnt_q   <= '0;
          we_q    <= win ? i_m1_we   : i_m0_we;
          sel_q   <= win ? i_m1_sel  : i_m0_sel;
          addr_q  <= win ? i_m1_addr : i_m0_addr;
          data_q  <= win ? i_m1_data : i_m0_data;
        end
        ISSUE: begin
          cnt_q   <= cnt_q + 8'd1;
          state_q <= (ack || tmo) ? IDLE : (i_s_stall ? ISSUE : WAIT_ACK);
        end
        WAIT_ACK: begin
          cnt_q   <= cnt_q + 8'd1;
          state_q <= (ack || tmo) ? IDLE : WAIT_ACK;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
